// File: rtl/timer_pkg.sv
// timer_pkg: command opcodes and state encoding shared by the timer unit.
package timer_pkg;
  localparam logic [2:0] TIM_OP_ENABLE  = 3'b000;
  localparam logic [2:0] TIM_OP_PSC_I   = 3'b001;
  localparam logic [2:0] TIM_OP_ARR_I   = 3'b010;
  localparam logic [2:0] TIM_OP_PSC_REG = 3'b100;
  localparam logic [2:0] TIM_OP_ARR_REG = 3'b101;
  localparam logic [2:0] TIM_OP_DISABLE = 3'b111;
  typedef enum logic {TIM_IDLE, TIM_RUN} timer_state_t;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the core clock, ticking once every psc_act+1 running cycles.
module timer_prescaler #(
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             restart,
  input  logic [PSC_W-1:0] psc_act,
  output logic             tick
);
  logic [PSC_W-1:0] psc_cnt_q;
  assign tick = run && (psc_cnt_q == psc_act);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) psc_cnt_q <= '0;
    else if (restart || tick) psc_cnt_q <= '0;
    else if (run) psc_cnt_q <= psc_cnt_q + PSC_W'(1);
endmodule

// File: rtl/timer_unit.sv
// timer_unit: prescaled up-counter with auto-reload, update pulse and sticky flag.
module timer_unit
  import timer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_imm,
  input  logic [31:0]      cmd_rs1,
  input  logic             flag_clr,
  output logic [CNT_W-1:0] tim_cnt,
  output logic             tim_running,
  output logic             tim_update,
  output logic             tim_flag,
  output logic [PSC_W-1:0] tim_psc,
  output logic [CNT_W-1:0] tim_arr
);
  timer_state_t     state_q;
  logic [CNT_W-1:0] cnt_q, arr_pre_q, arr_act_q;
  logic [PSC_W-1:0] psc_pre_q, psc_act_q;
  logic             update_q, flag_q;
  logic             tick, wrap, start, stop, psc_wr, arr_wr;
  logic [PSC_W-1:0] psc_val;
  logic [CNT_W-1:0] arr_val;
  always_comb begin
    start   = cmd_valid && cmd_op == TIM_OP_ENABLE && state_q == TIM_IDLE;
    stop    = cmd_valid && cmd_op == TIM_OP_DISABLE && state_q == TIM_RUN;
    psc_wr  = cmd_valid && (cmd_op == TIM_OP_PSC_I || cmd_op == TIM_OP_PSC_REG);
    arr_wr  = cmd_valid && (cmd_op == TIM_OP_ARR_I || cmd_op == TIM_OP_ARR_REG);
    psc_val = cmd_op == TIM_OP_PSC_I ? cmd_imm[PSC_W-1:0] : cmd_rs1[PSC_W-1:0];
    arr_val = cmd_op == TIM_OP_ARR_I ? cmd_imm[CNT_W-1:0] : cmd_rs1[CNT_W-1:0];
    wrap    = tick && cnt_q == arr_act_q;
  end
  timer_prescaler #(.PSC_W(PSC_W)) u_psc (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (state_q == TIM_RUN),
    .restart (start),
    .psc_act (psc_act_q),
    .tick    (tick)
  );
  // A count above ARR simply overflows to zero without a wrap event.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= TIM_IDLE;
      cnt_q     <= '0;
      psc_pre_q <= '0;
      psc_act_q <= '0;
      arr_pre_q <= '1;
      arr_act_q <= '1;
      update_q  <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      update_q <= wrap;
      flag_q   <= wrap | (flag_q & ~flag_clr);
      if (psc_wr) psc_pre_q <= psc_val;
      if (arr_wr) arr_pre_q <= arr_val;
      if (tick) cnt_q <= wrap ? '0 : cnt_q + CNT_W'(1);
      if (start || wrap) begin
        psc_act_q <= psc_pre_q;
        arr_act_q <= arr_pre_q;
      end
      if (start) state_q <= TIM_RUN;
      else if (stop) state_q <= TIM_IDLE;
    end
  assign tim_cnt     = cnt_q;
  assign tim_running = state_q == TIM_RUN;
  assign tim_update  = update_q;
  assign tim_flag    = flag_q;
  assign tim_psc     = psc_pre_q;
  assign tim_arr     = arr_pre_q;
endmodule

// File: tb/tb_timer_unit.sv
// tb_timer_unit: directed vectors for timer_unit; a narrow-counter copy covers overflow past ARR.
module tb_timer_unit;
  logic        clk = 1'b0, reset_n = 1'b0, cmd_valid = 1'b0, flag_clr = 1'b0;
  logic [2:0]  cmd_op = 3'b0;
  logic [31:0] cmd_imm = '0, cmd_rs1 = '0;
  logic [31:0] tim_cnt, tim_arr;
  logic [15:0] tim_psc, tim_psc8;
  logic [7:0]  tim_cnt8, tim_arr8;
  logic        tim_running, tim_update, tim_flag;
  logic        tim_running8, tim_update8, tim_flag8;
  int          nvec = 0, nerr = 0;
  logic        seen;

  always #5 clk = ~clk;

  timer_unit u_dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_imm(cmd_imm), .cmd_rs1(cmd_rs1), .flag_clr(flag_clr),
    .tim_cnt(tim_cnt), .tim_running(tim_running), .tim_update(tim_update),
    .tim_flag(tim_flag), .tim_psc(tim_psc), .tim_arr(tim_arr)
  );

  timer_unit #(.CNT_W(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_imm(cmd_imm), .cmd_rs1(cmd_rs1), .flag_clr(flag_clr),
    .tim_cnt(tim_cnt8), .tim_running(tim_running8), .tim_update(tim_update8),
    .tim_flag(tim_flag8), .tim_psc(tim_psc8), .tim_arr(tim_arr8)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cmd(input logic [2:0] op, input logic [31:0] imm, input logic [31:0] rs1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_imm   = imm;
    cmd_rs1   = rs1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    #1;
    chk("rst_cnt", tim_cnt, 0);
    chk("rst_run", tim_running, 0);
    chk("rst_upd", tim_update, 0);
    chk("rst_flag", tim_flag, 0);
    chk("rst_psc", tim_psc, 0);
    chk("rst_arr", tim_arr, 32'hFFFF_FFFF);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #12;
    do_reset;
    // period 4, one step per cycle
    cmd(3'b001, 0, 0);
    cmd(3'b010, 3, 0);
    chk("arr_rb3", tim_arr, 3);
    cmd(3'b000, 0, 0);
    chk("en_run", tim_running, 1);
    chk("en_cnt", tim_cnt, 0);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk("p4_cnt", tim_cnt, i % 4);
      chk("p4_upd", tim_update, (i % 4) == 0);
      chk("p4_flag", tim_flag, i >= 4);
    end
    do_reset;
    // prescaler 2, ARR 1
    cmd(3'b001, 2, 0);
    chk("psc_rb2", tim_psc, 2);
    cmd(3'b010, 1, 0);
    cmd(3'b000, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("ps_cnt", tim_cnt, (k / 3) % 2);
      chk("ps_upd", tim_update, (k % 6) == 0);
      chk("ps_flag", tim_flag, k >= 6);
    end
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    chk("clr_flag", tim_flag, 0);
    repeat (4) @(negedge clk);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    chk("clrset_upd", tim_update, 1);
    chk("clrset_flag", tim_flag, 1);
    do_reset;
    // ARR preload write mid-period
    cmd(3'b001, 0, 0);
    cmd(3'b010, 3, 0);
    cmd(3'b000, 0, 0);
    @(negedge clk);
    chk("ar_cnt1", tim_cnt, 1);
    cmd(3'b101, 99, 7);
    chk("ar_rb7", tim_arr, 7);
    chk("ar_cnt2", tim_cnt, 2);
    @(negedge clk);
    @(negedge clk);
    chk("ar_wrap_cnt", tim_cnt, 0);
    chk("ar_wrap_upd", tim_update, 1);
    repeat (7) @(negedge clk);
    chk("ar_cnt7", tim_cnt, 7);
    chk("ar_cnt7_upd", tim_update, 0);
    @(negedge clk);
    chk("ar_wrap2_cnt", tim_cnt, 0);
    chk("ar_wrap2_upd", tim_update, 1);
    @(negedge clk);
    // disable / resume
    cmd(3'b111, 0, 0);
    chk("dis_cnt", tim_cnt, 2);
    chk("dis_run", tim_running, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_cnt", tim_cnt, 2);
      chk("hold_run", tim_running, 0);
    end
    cmd(3'b000, 0, 0);
    chk("res_run", tim_running, 1);
    chk("res_cnt2", tim_cnt, 2);
    @(negedge clk);
    chk("res_cnt3", tim_cnt, 3);
    repeat (4) @(negedge clk);
    chk("res_cnt7", tim_cnt, 7);
    cmd(3'b111, 0, 0);
    chk("dwrap_cnt", tim_cnt, 0);
    chk("dwrap_upd", tim_update, 1);
    chk("dwrap_run", tim_running, 0);
    chk("dwrap_flag", tim_flag, 1);
    @(negedge clk);
    chk("dwrap_upd0", tim_update, 0);
    chk("dwrap_cnt0", tim_cnt, 0);
    // ignored commands
    cmd_op = 3'b000;
    @(negedge clk);
    chk("novalid_run", tim_running, 0);
    cmd(3'b011, 5, 5);
    chk("badop_run", tim_running, 0);
    chk("badop_psc", tim_psc, 0);
    chk("badop_arr", tim_arr, 7);
    // count above ARR runs through all-ones
    cmd(3'b000, 0, 0);
    repeat (4) @(negedge clk);
    chk("ov_cnt4", tim_cnt, 4);
    cmd(3'b111, 0, 0);
    chk("ov_cnt5", tim_cnt, 5);
    cmd(3'b010, 2, 0);
    chk("ov_arr2", tim_arr, 2);
    cmd(3'b000, 0, 0);
    chk("ov_en_cnt", tim_cnt8, 5);
    seen = 1'b0;
    for (int j = 1; j <= 251; j++) begin
      @(negedge clk);
      seen = seen | tim_update | tim_update8;
    end
    chk("ov_no_upd", seen, 0);
    chk("ov_cnt8_wrap", tim_cnt8, 0);
    chk("ov_cnt32", tim_cnt, 256);
    repeat (3) @(negedge clk);
    chk("ov_cnt8_arr", tim_cnt8, 0);
    chk("ov_upd8", tim_update8, 1);
    chk("ov_upd32", tim_update, 0);
    chk("ov_cnt32b", tim_cnt, 259);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
